// File: rtl/nettlp_cmd_arb.sv
// nettlp_cmd_arb: round-robin arbiter between two NetTLP command requesters
// (A = network, B = local) feeding a single command core. Only one read may
// be outstanding; its response is routed back to the requester that issued
// it. All outputs come straight from flops.
//
// Command word layout (CMD_W = 72):
//   [71:64] opcode, [63:32] dwaddr, [31:0] data
module nettlp_cmd_arb #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CMD_W          = 72
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester A command FIFO (FWFT read side)
  input  logic             req_a_empty,
  input  logic [CMD_W-1:0] req_a_dout,
  output logic             req_a_rd_en,
  // requester B command FIFO (FWFT read side)
  input  logic             req_b_empty,
  input  logic [CMD_W-1:0] req_b_dout,
  output logic             req_b_rd_en,
  // command core input FIFO (write side)
  output logic             cmd_o_wr_en,
  input  logic             cmd_o_full,
  output logic [CMD_W-1:0] cmd_o_din,
  // command core output FIFO (FWFT read side)
  input  logic             rsp_i_empty,
  input  logic [CMD_W-1:0] rsp_i_dout,
  output logic             rsp_i_rd_en,
  // response FIFO to requester A (write side)
  output logic             rsp_a_wr_en,
  input  logic             rsp_a_full,
  output logic [CMD_W-1:0] rsp_a_din,
  // response FIFO to requester B (write side)
  output logic             rsp_b_wr_en,
  input  logic             rsp_b_full,
  output logic [CMD_W-1:0] rsp_b_din,
  // status
  output logic             busy,
  output logic [15:0]      stat_timeout_cnt,
  output logic [15:0]      stat_drop_cnt
);

  localparam logic [7:0]  NETTLP_OPC_REG_RD = 8'h02;
  localparam logic [15:0] TMO_LAST          = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        GNT_A             = 1'b0;
  localparam logic        GNT_B             = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DELIVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;     // requester owning the current transaction
  logic               last_q, last_d;       // requester issued most recently
  logic [15:0]        timer_q, timer_d;
  logic [CMD_W-1:0]   rsp_q, rsp_d;         // response held for DELIVER

  logic               req_a_rd_en_q, req_a_rd_en_d;
  logic               req_b_rd_en_q, req_b_rd_en_d;
  logic               cmd_o_wr_en_q, cmd_o_wr_en_d;
  logic [CMD_W-1:0]   cmd_o_din_q, cmd_o_din_d;
  logic               rsp_i_rd_en_q, rsp_i_rd_en_d;
  logic               rsp_a_wr_en_q, rsp_a_wr_en_d;
  logic [CMD_W-1:0]   rsp_a_din_q, rsp_a_din_d;
  logic               rsp_b_wr_en_q, rsp_b_wr_en_d;
  logic [CMD_W-1:0]   rsp_b_din_q, rsp_b_din_d;
  logic               busy_q, busy_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic [CMD_W-1:0]   sel_dout;
  logic               pop_in_flight;

  assign sel_dout = (grant_q == GNT_B) ? req_b_dout : req_a_dout;

  // A pop issued last cycle has not yet reached the FWFT flags; acting on
  // them now could pop the same entry twice.
  assign pop_in_flight = req_a_rd_en_q | req_b_rd_en_q | rsp_i_rd_en_q;

  // Next-state and next-output logic; every pulse defaults low.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    timer_d       = timer_q;
    rsp_d         = rsp_q;
    req_a_rd_en_d = 1'b0;
    req_b_rd_en_d = 1'b0;
    cmd_o_wr_en_d = 1'b0;
    cmd_o_din_d   = cmd_o_din_q;
    rsp_i_rd_en_d = 1'b0;
    rsp_a_wr_en_d = 1'b0;
    rsp_a_din_d   = rsp_a_din_q;
    rsp_b_wr_en_d = 1'b0;
    rsp_b_din_d   = rsp_b_din_q;
    tmo_cnt_d     = tmo_cnt_q;
    drop_cnt_d    = drop_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (!pop_in_flight) begin
          if (!rsp_i_empty) begin
            // nobody is waiting for this response: drain and count it
            rsp_i_rd_en_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else if (!req_a_empty && (req_b_empty || last_q == GNT_B)) begin
            grant_d = GNT_A;
            state_d = ISSUE;
          end else if (!req_b_empty) begin
            grant_d = GNT_B;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (!cmd_o_full) begin
          req_a_rd_en_d = (grant_q == GNT_A);
          req_b_rd_en_d = (grant_q == GNT_B);
          cmd_o_wr_en_d = 1'b1;
          cmd_o_din_d   = sel_dout;
          last_d        = grant_q;
          timer_d       = 16'd0;
          // only register reads expect a response; anything else is fire-and-forget
          if (sel_dout[CMD_W-1 -: 8] == NETTLP_OPC_REG_RD) state_d = WAIT_RSP;
          else                                             state_d = IDLE;
        end
      end

      WAIT_RSP: begin
        if (!rsp_i_empty) begin
          // arrival wins over a coincident timeout
          rsp_d         = rsp_i_dout;
          rsp_i_rd_en_d = 1'b1;
          state_d       = DELIVER;
        end else if (timer_q == TMO_LAST) begin
          // unmapped reads never answer; give up and free the core
          if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      DELIVER: begin
        if (grant_q == GNT_A) begin
          if (!rsp_a_full) begin
            rsp_a_wr_en_d = 1'b1;
            rsp_a_din_d   = rsp_q;
            state_d       = IDLE;
          end
        end else begin
          if (!rsp_b_full) begin
            rsp_b_wr_en_d = 1'b1;
            rsp_b_din_d   = rsp_q;
            state_d       = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // busy mirrors the state that will be current next cycle
  always_comb begin
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers; reset leaves B as last grant so A wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= GNT_A;
      last_q        <= GNT_B;
      timer_q       <= '0;
      rsp_q         <= '0;
      req_a_rd_en_q <= 1'b0;
      req_b_rd_en_q <= 1'b0;
      cmd_o_wr_en_q <= 1'b0;
      cmd_o_din_q   <= '0;
      rsp_i_rd_en_q <= 1'b0;
      rsp_a_wr_en_q <= 1'b0;
      rsp_a_din_q   <= '0;
      rsp_b_wr_en_q <= 1'b0;
      rsp_b_din_q   <= '0;
      busy_q        <= 1'b0;
      tmo_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      rsp_q         <= rsp_d;
      req_a_rd_en_q <= req_a_rd_en_d;
      req_b_rd_en_q <= req_b_rd_en_d;
      cmd_o_wr_en_q <= cmd_o_wr_en_d;
      cmd_o_din_q   <= cmd_o_din_d;
      rsp_i_rd_en_q <= rsp_i_rd_en_d;
      rsp_a_wr_en_q <= rsp_a_wr_en_d;
      rsp_a_din_q   <= rsp_a_din_d;
      rsp_b_wr_en_q <= rsp_b_wr_en_d;
      rsp_b_din_q   <= rsp_b_din_d;
      busy_q        <= busy_d;
      tmo_cnt_q     <= tmo_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign req_a_rd_en      = req_a_rd_en_q;
  assign req_b_rd_en      = req_b_rd_en_q;
  assign cmd_o_wr_en      = cmd_o_wr_en_q;
  assign cmd_o_din        = cmd_o_din_q;
  assign rsp_i_rd_en      = rsp_i_rd_en_q;
  assign rsp_a_wr_en      = rsp_a_wr_en_q;
  assign rsp_a_din        = rsp_a_din_q;
  assign rsp_b_wr_en      = rsp_b_wr_en_q;
  assign rsp_b_din        = rsp_b_din_q;
  assign busy             = busy_q;
  assign stat_timeout_cnt = tmo_cnt_q;
  assign stat_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_nettlp_cmd_arb.sv
// Bench for nettlp_cmd_arb: FWFT FIFOs and a command core are modelled with
// queues; expected grant order comes from a round-robin reference model.
module tb_nettlp_cmd_arb;
  localparam int          TMO        = 8;
  localparam int          W          = 72;
  localparam logic [7:0]  OPC_WR     = 8'h01;
  localparam logic [7:0]  OPC_RD     = 8'h02;
  localparam logic [31:0] MAGIC      = 32'h0000_0010;
  localparam logic [31:0] MAGIC_DATA = 32'h6745_2301;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_a_empty = 1'b1, req_b_empty = 1'b1, rsp_i_empty = 1'b1;
  logic [W-1:0] req_a_dout = '0, req_b_dout = '0, rsp_i_dout = '0;
  logic         req_a_rd_en, req_b_rd_en, rsp_i_rd_en;
  logic         cmd_o_wr_en, rsp_a_wr_en, rsp_b_wr_en;
  logic         cmd_o_full = 1'b0, rsp_a_full = 1'b0, rsp_b_full = 1'b0;
  logic [W-1:0] cmd_o_din, rsp_a_din, rsp_b_din;
  logic         busy;
  logic [15:0]  stat_timeout_cnt, stat_drop_cnt;

  nettlp_cmd_arb #(.TIMEOUT_CYCLES(TMO), .CMD_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_empty(req_a_empty), .req_a_dout(req_a_dout), .req_a_rd_en(req_a_rd_en),
    .req_b_empty(req_b_empty), .req_b_dout(req_b_dout), .req_b_rd_en(req_b_rd_en),
    .cmd_o_wr_en(cmd_o_wr_en), .cmd_o_full(cmd_o_full), .cmd_o_din(cmd_o_din),
    .rsp_i_empty(rsp_i_empty), .rsp_i_dout(rsp_i_dout), .rsp_i_rd_en(rsp_i_rd_en),
    .rsp_a_wr_en(rsp_a_wr_en), .rsp_a_full(rsp_a_full), .rsp_a_din(rsp_a_din),
    .rsp_b_wr_en(rsp_b_wr_en), .rsp_b_full(rsp_b_full), .rsp_b_din(rsp_b_din),
    .busy(busy), .stat_timeout_cnt(stat_timeout_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 clk = ~clk;

  // environment state
  logic [W-1:0] qa[$], qb[$], qrsp[$];
  logic [W-1:0] cmd_log[$], rspa_log[$], rspb_log[$];
  bit           src_log[$];
  int           due_q[$];
  logic [W-1:0] due_w[$];
  int           cyc = 0;
  int           n_a_pop = 0, n_b_pop = 0, n_rsp_pop = 0;
  int           last_rsp_pop_cyc = 0, last_cmd_cyc = 0;

  // reference-model state
  bit           m_last_b = 1'b1;
  int           m_tmo = 0, m_drop = 0;

  int errs = 0, checks = 0;

  function automatic logic [W-1:0] mk(input logic [7:0] o, input logic [31:0] a, input logic [31:0] d);
    return {o, a, d};
  endfunction

  // FIFOs and core: pops and captures happen on the clock edge; flags follow via NBA
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_a_rd_en) begin
      if (qa.size() > 0) void'(qa.pop_front());
      src_log.push_back(1'b0);
      n_a_pop <= n_a_pop + 1;
    end
    if (req_b_rd_en) begin
      if (qb.size() > 0) void'(qb.pop_front());
      src_log.push_back(1'b1);
      n_b_pop <= n_b_pop + 1;
    end
    if (cmd_o_wr_en) begin
      cmd_log.push_back(cmd_o_din);
      last_cmd_cyc <= cyc;
      if (cmd_o_din[71:64] == OPC_RD && cmd_o_din[63:32] == MAGIC) begin
        due_q.push_back(cyc + 3);
        due_w.push_back(mk(OPC_RD, MAGIC, MAGIC_DATA));
      end
    end
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      qrsp.push_back(due_w[0]);
      void'(due_q.pop_front());
      void'(due_w.pop_front());
    end
    if (rsp_i_rd_en) begin
      if (qrsp.size() > 0) void'(qrsp.pop_front());
      n_rsp_pop <= n_rsp_pop + 1;
      last_rsp_pop_cyc <= cyc;
    end
    if (rsp_a_wr_en) rspa_log.push_back(rsp_a_din);
    if (rsp_b_wr_en) rspb_log.push_back(rsp_b_din);
    req_a_empty <= (qa.size() == 0);
    req_a_dout  <= (qa.size() > 0) ? qa[0] : '0;
    req_b_empty <= (qb.size() == 0);
    req_b_dout  <= (qb.size() > 0) ? qb[0] : '0;
    rsp_i_empty <= (qrsp.size() == 0);
    rsp_i_dout  <= (qrsp.size() > 0) ? qrsp[0] : '0;
  end

  task automatic wait_cmds(input int n, input int budget, output bit ok);
    int k = 0;
    while (cmd_log.size() < n && k < budget) begin @(negedge clk); k++; end
    ok = (cmd_log.size() >= n);
  endtask

  task automatic test_reset();
    logic [3*W+5:0] outs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    outs = {req_a_rd_en, req_b_rd_en, rsp_i_rd_en, cmd_o_wr_en, rsp_a_wr_en, rsp_b_wr_en,
            cmd_o_din, rsp_a_din, rsp_b_din};
    checks++; if (outs !== '0) begin errs++; $display("FAIL reset_outs got=%h want=0", outs); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (stat_timeout_cnt !== 16'd0 || stat_drop_cnt !== 16'd0) begin
      errs++; $display("FAIL reset_stats got=%0d/%0d want=0/0", stat_timeout_cnt, stat_drop_cnt);
    end
    rst_n = 1'b1;
    m_last_b = 1'b1; m_tmo = 0; m_drop = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rr_writes(input int iter);
    logic [W-1:0] wa[$], wb[$], exp_w[$];
    bit           exp_src[$];
    int na, nb, ia, ib, s_cmd, s_src, s_ra, s_rb, s_pa, s_pb;
    bit ok, pick_b;
    logic [7:0] o;
    na = $urandom_range(1, 4); nb = $urandom_range(1, 4);
    for (int i = 0; i < na + nb; i++) begin
      o = ($urandom_range(0, 1) == 0) ? OPC_WR : 8'($urandom_range(0, 255));
      if (o == OPC_RD) o = 8'h03;
      if (i < na) wa.push_back(mk(o, $urandom, $urandom));
      else        wb.push_back(mk(o, $urandom, $urandom));
    end
    // reference: alternate while both have work, otherwise drain whichever remains
    ia = 0; ib = 0;
    while (ia < na || ib < nb) begin
      if (ia < na && ib < nb) pick_b = !m_last_b;
      else                    pick_b = (ib < nb);
      exp_src.push_back(pick_b);
      if (pick_b) begin exp_w.push_back(wb[ib]); ib++; end
      else        begin exp_w.push_back(wa[ia]); ia++; end
      m_last_b = pick_b;
    end
    s_cmd = cmd_log.size(); s_src = src_log.size();
    s_ra = rspa_log.size(); s_rb = rspb_log.size(); s_pa = n_a_pop; s_pb = n_b_pop;
    @(negedge clk);
    foreach (wa[i]) qa.push_back(wa[i]);
    foreach (wb[i]) qb.push_back(wb[i]);
    wait_cmds(s_cmd + na + nb, 200, ok);
    repeat (6) @(negedge clk);
    checks++; if (!ok || cmd_log.size() != s_cmd + na + nb) begin
      errs++; $display("FAIL rr%0d_cmd_count got=%0d want=%0d", iter, cmd_log.size() - s_cmd, na + nb);
    end else begin
      for (int i = 0; i < na + nb; i++) begin
        checks++; if (cmd_log[s_cmd+i] !== exp_w[i] || src_log[s_src+i] !== exp_src[i]) begin
          errs++; $display("FAIL rr%0d_order[%0d] got=%h/src%0d want=%h/src%0d", iter, i,
                           cmd_log[s_cmd+i], src_log[s_src+i], exp_w[i], exp_src[i]);
        end
      end
    end
    checks++; if (n_a_pop - s_pa != na || n_b_pop - s_pb != nb) begin
      errs++; $display("FAIL rr%0d_pops got=%0d/%0d want=%0d/%0d", iter, n_a_pop - s_pa, n_b_pop - s_pb, na, nb);
    end
    checks++; if (rspa_log.size() != s_ra || rspb_log.size() != s_rb) begin
      errs++; $display("FAIL rr%0d_no_rsp got=%0d/%0d want=0/0", iter, rspa_log.size() - s_ra, rspb_log.size() - s_rb);
    end
  endtask

  task automatic test_read_b_magic();
    logic [W-1:0] cmd;
    int s_ra, s_rb, s_cmd, k;
    cmd = mk(OPC_RD, MAGIC, $urandom);
    s_ra = rspa_log.size(); s_rb = rspb_log.size(); s_cmd = cmd_log.size();
    @(negedge clk);
    qb.push_back(cmd);
    k = 0;
    while (rspb_log.size() == s_rb && k < 100) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    m_last_b = 1'b1;
    checks++; if (rspb_log.size() != s_rb + 1) begin
      errs++; $display("FAIL rdb_rsp_count got=%0d want=1", rspb_log.size() - s_rb);
    end else begin
      checks++; if (rspb_log[s_rb] !== mk(OPC_RD, MAGIC, MAGIC_DATA)) begin
        errs++; $display("FAIL rdb_rsp_data got=%h want=%h", rspb_log[s_rb], mk(OPC_RD, MAGIC, MAGIC_DATA));
      end
    end
    checks++; if (rspa_log.size() != s_ra) begin
      errs++; $display("FAIL rdb_no_rsp_a got=%0d want=0", rspa_log.size() - s_ra);
    end
    checks++; if (cmd_log.size() != s_cmd + 1 || cmd_log[s_cmd] !== cmd) begin
      errs++; $display("FAIL rdb_passthru got=%0d cmds want=1 cmd %h", cmd_log.size() - s_cmd, cmd);
    end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rdb_idle got=%b want=0", busy); end
  endtask

  task automatic test_timeout();
    int k, s_ra, s_rb;
    s_ra = rspa_log.size(); s_rb = rspb_log.size();
    @(negedge clk);
    qa.push_back(mk(OPC_RD, 32'hDEAD_0000, $urandom));
    k = 0;
    while (cmd_o_wr_en !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    checks++; if (cmd_o_wr_en !== 1'b1) begin
      errs++; $display("FAIL tmo_issue got=no issue want=issue within 50 cycles");
    end else begin
      k = 0;
      do begin @(negedge clk); k++; end while (busy === 1'b1 && k < 50);
      checks++; if (k != TMO) begin errs++; $display("FAIL tmo_latency got=%0d want=%0d", k, TMO); end
    end
    m_last_b = 1'b0; m_tmo++;
    checks++; if (stat_timeout_cnt !== 16'(m_tmo)) begin
      errs++; $display("FAIL tmo_cnt got=%0d want=%0d", stat_timeout_cnt, m_tmo);
    end
    checks++; if (stat_drop_cnt !== 16'(m_drop)) begin
      errs++; $display("FAIL tmo_drop got=%0d want=%0d", stat_drop_cnt, m_drop);
    end
    checks++; if (rspa_log.size() != s_ra || rspb_log.size() != s_rb) begin
      errs++; $display("FAIL tmo_no_rsp got=%0d/%0d want=0/0", rspa_log.size() - s_ra, rspb_log.size() - s_rb);
    end
  endtask

  task automatic test_late_rsp();
    logic [W-1:0] cmd;
    int s_cmd, s_src, s_ra, s_rb, s_pop;
    bit ok;
    cmd = mk(OPC_WR, $urandom, $urandom);
    s_cmd = cmd_log.size(); s_src = src_log.size();
    s_ra = rspa_log.size(); s_rb = rspb_log.size(); s_pop = n_rsp_pop;
    @(negedge clk);
    qrsp.push_back(mk(OPC_RD, 32'hDEAD_0000, $urandom));
    qb.push_back(cmd);
    wait_cmds(s_cmd + 1, 50, ok);
    repeat (4) @(negedge clk);
    m_drop++; m_last_b = 1'b1;
    checks++; if (stat_drop_cnt !== 16'(m_drop)) begin
      errs++; $display("FAIL late_drop_cnt got=%0d want=%0d", stat_drop_cnt, m_drop);
    end
    checks++; if (n_rsp_pop - s_pop != 1) begin
      errs++; $display("FAIL late_pop got=%0d want=1", n_rsp_pop - s_pop);
    end
    checks++; if (!ok || cmd_log[s_cmd] !== cmd || src_log[s_src] !== 1'b1) begin
      errs++; $display("FAIL late_grant got=%0d cmds want=1 from B", cmd_log.size() - s_cmd);
    end
    checks++; if (!(last_rsp_pop_cyc < last_cmd_cyc)) begin
      errs++; $display("FAIL late_order got=pop@%0d cmd@%0d want=pop first", last_rsp_pop_cyc, last_cmd_cyc);
    end
    checks++; if (rspa_log.size() != s_ra || rspb_log.size() != s_rb) begin
      errs++; $display("FAIL late_no_rsp got=%0d/%0d want=0/0", rspa_log.size() - s_ra, rspb_log.size() - s_rb);
    end
  endtask

  task automatic test_full_hold();
    logic [W-1:0] cmd;
    int s_cmd, s_pa, k;
    bit ok;
    cmd = mk(OPC_WR, $urandom, $urandom);
    s_cmd = cmd_log.size(); s_pa = n_a_pop;
    @(negedge clk);
    cmd_o_full = 1'b1;
    qa.push_back(cmd);
    k = 0;
    while (busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL full_grant got=busy %b want=1", busy); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (cmd_o_wr_en !== 1'b0 || req_a_rd_en !== 1'b0) begin
        errs++; $display("FAIL full_hold[%0d] got=wr%b/rd%b want=0/0", i, cmd_o_wr_en, req_a_rd_en);
      end
    end
    cmd_o_full = 1'b0;
    wait_cmds(s_cmd + 1, 20, ok);
    repeat (4) @(negedge clk);
    m_last_b = 1'b0;
    checks++; if (!ok || cmd_log.size() != s_cmd + 1 || cmd_log[s_cmd] !== cmd) begin
      errs++; $display("FAIL full_issue got=%0d cmds want=1 cmd %h", cmd_log.size() - s_cmd, cmd);
    end
    checks++; if (n_a_pop - s_pa != cmd_log.size() - s_cmd) begin
      errs++; $display("FAIL full_pop_match got=%0d pops want=%0d", n_a_pop - s_pa, cmd_log.size() - s_cmd);
    end
  endtask

  task automatic test_reset_mid();
    logic [3*W+5:0] outs;
    int k, s_src;
    bit ok;
    @(negedge clk);
    qa.push_back(mk(OPC_RD, 32'hBEEF_0000, $urandom));
    k = 0;
    while (cmd_o_wr_en !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rstmid_wait got=busy %b want=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    outs = {req_a_rd_en, req_b_rd_en, rsp_i_rd_en, cmd_o_wr_en, rsp_a_wr_en, rsp_b_wr_en,
            cmd_o_din, rsp_a_din, rsp_b_din};
    checks++; if (outs !== '0 || busy !== 1'b0) begin
      errs++; $display("FAIL rstmid_outs got=%h busy=%b want=0", outs, busy);
    end
    checks++; if (stat_timeout_cnt !== 16'd0 || stat_drop_cnt !== 16'd0) begin
      errs++; $display("FAIL rstmid_stats got=%0d/%0d want=0/0", stat_timeout_cnt, stat_drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_last_b = 1'b1; m_tmo = 0; m_drop = 0;
    @(negedge clk);
    s_src = src_log.size();
    qa.push_back(mk(OPC_WR, $urandom, $urandom));
    qb.push_back(mk(OPC_WR, $urandom, $urandom));
    wait_cmds(cmd_log.size() + 2, 50, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok || src_log.size() < s_src + 2 || src_log[s_src] !== 1'b0 || src_log[s_src+1] !== 1'b1) begin
      errs++; $display("FAIL rstmid_first_grant got=%0d grants want=A then B", src_log.size() - s_src);
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 3; i++) test_rr_writes(i);
    test_read_b_magic();
    test_timeout();
    test_late_rsp();
    test_full_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
